alu181_seq: RTL and testbench
=============================

# alu181_seq

Slice-serial, parametrised successor to the 16-bit 74181-style ALU. It evaluates full 74181 function semantics (16 logic and 16 arithmetic operations) on WIDTH-bit operands using SPC 4-bit slices per cycle, with the carry held in a register between cycles. A valid/ready handshake on both input and output lets it sit between the register-file read stage and the writeback stage of the 16-bit CPU datapath. It also produces carry, zero and signed-overflow flags.

## Interface
- WIDTH, 16: operand width; must be a multiple of 4*SPC, otherwise elaboration error.
- SPC, 1: 4-bit slices evaluated per cycle. N = WIDTH/(4*SPC) compute cycles.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE.
- s  in  4  74181 function select.
- m  in  1  1 = logic mode, 0 = arithmetic mode.
- cin  in  1  active-high carry-in (1 = +1); ignored when m=1.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts result.
- y  out  WIDTH  result.
- cout  out  1  carry out of MSB; 0 when m=1.
- zero  out  1  y == 0.
- ovf  out  1  carry into MSB XOR cout; 0 when m=1.

## Operation
- Semantics follow the active-high 74181 datasheet, with active-high carry.
  - Arithmetic examples: s=1001 gives A+B+cin; s=0110 gives A+~B+cin, so A−B when cin=1; s=0000 gives A+cin; s=1111 gives A−1+cin.
  - Logic examples: 0000 gives ~A; 0110 gives A^B; 1001 gives ~(A^B); 1011 gives A&B; 1110 gives A|B; 0011 gives 0; 1100 gives all ones; 1111 gives A.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: latch a, b, s, m, cin; set carry_reg = cin & ~m; set cnt=0; go to RUN.
- RUN:
  - Each edge processes slice group cnt (bits [4*SPC*cnt +: 4*SPC]) from the latched operands and carry_reg.
  - The result is written into y_reg at that bit position, and carry_reg is updated.
  - When cnt == N−1, latch the flags and go to DONE; otherwise cnt++.
- DONE:
  - out_valid=1; y and flags are stable.
  - On out_ready at an edge, go to IDLE.
- Inputs are ignored outside IDLE. in_valid while busy is not queued.
- ovf uses the carry into bit WIDTH−1, captured during the final slice group.

## Timing
- Reset values: state=IDLE, y=0, cout=0, zero=0, ovf=0, out_valid=0, in_ready=1, cnt=0, carry_reg=0.
- Latency: out_valid rises N edges after the accepting edge.
- Minimum issue interval is N+2 cycles: accept, then N RUN edges, then the DONE/out_ready edge, then IDLE.
- in_ready and out_valid are decoded from state. There are no combinational paths from in_valid or out_ready to outputs.
- y and the flags do not change between entering DONE and leaving it. They hold their values in IDLE until the next result is written.
- Reset during RUN or DONE:
  - The operation is abandoned and no out_valid pulse is produced.
  - All outputs return to their reset values immediately (asynchronous).
- N=1 (e.g. WIDTH=4, SPC=1): RUN lasts exactly one edge.

## Structure
- Package alu181_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - named 4-bit select constants (S_ADD=1001, S_SUB=0110, S_XOR=0110, S_AND=1011, S_OR=1110, S_NOTA=0000, S_ZERO=0011, S_ONES=1100, S_PASSA=1111).
- Sub-module alu181_slice:
  - purely combinational 4-bit 74181 (s, m, cin, a[3:0], b[3:0] → f[3:0], cout, c3 = carry into bit 3);
  - instantiated SPC times with carries chained.
- Top level holds the FSM, counter, operand and result registers, and flag logic.

## Test plan
- ADD, WIDTH=16, SPC=1: a=0x1234, b=0x0FFF, s=1001, m=0, cin=0 → y=0x2233, cout=0, ovf=0, zero=0; out_valid rises exactly 4 edges after acceptance.
- SUB: a=0x8000, b=0x0001, s=0110, m=0, cin=1 → y=0x7FFF, cout=1, ovf=1.
- Logic: XOR with a=0xFF00, b=0x0FF0, m=1 → y=0xF0F0, cout=0, ovf=0.
  - XOR with a=b=0xABCD → y=0, zero=1.
  - cin=1 with m=1 has no effect.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid/a/b → y and flags stable, in_ready=0, no new op taken. Raise out_ready → IDLE next edge, and the next op completes correctly.
- Reset mid-RUN: assert rst after 2 slice edges → out_valid=0, y=0, in_ready=1 immediately. A following ADD of 0x0001+0x0001 gives 0x0002.
- WIDTH=32, SPC=2: a=0xFFFFFFFF, b=0x00000001, s=1001, m=0, cin=0 → y=0, cout=1, zero=1, ovf=0; latency 4 edges.

Source files
------------

// File: rtl/alu181_pkg.sv
// Shared types and 74181 function-select constants for the slice-serial ALU.
package alu181_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] S_ADD   = 4'b1001;
    localparam logic [3:0] S_SUB   = 4'b0110;
    localparam logic [3:0] S_XOR   = 4'b0110;
    localparam logic [3:0] S_AND   = 4'b1011;
    localparam logic [3:0] S_OR    = 4'b1110;
    localparam logic [3:0] S_NOTA  = 4'b0000;
    localparam logic [3:0] S_ZERO  = 4'b0011;
    localparam logic [3:0] S_ONES  = 4'b1100;
    localparam logic [3:0] S_PASSA = 4'b1111;

endpackage

// File: rtl/alu181_slice.sv
// Combinational 4-bit 74181 slice, active-high data and active-high carry.
module alu181_slice
    import alu181_pkg::*;
(
    input  logic [3:0] s_i,
    input  logic       m_i,
    input  logic       cin_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] f_o,
    output logic       cout_o,
    output logic       c3_o
);

    logic [3:0] x;
    logic [3:0] g;
    logic [4:0] c;

    // Arithmetic is x + g + cin; g implies x, so x alone propagates and g generates.
    always_comb begin
        x    = a_i | (b_i & {4{s_i[0]}}) | (~b_i & {4{s_i[1]}});
        g    = (a_i & ~b_i & {4{s_i[2]}}) | (a_i & b_i & {4{s_i[3]}});
        c    = '0;
        c[0] = cin_i;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g[i] | (x[i] & c[i]);
        end
        f_o    = m_i ? ~(x ^ g) : (x ^ g ^ c[3:0]);
        cout_o = c[4];
        c3_o   = c[3];
    end

endmodule

// File: rtl/alu181_seq.sv
// Slice-serial 74181 ALU: SPC 4-bit slices per cycle, carry held between cycles,
// valid/ready handshake on both sides, carry/zero/signed-overflow flags.
module alu181_seq
    import alu181_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned GW = 4 * SPC;
    localparam int unsigned N  = WIDTH / GW;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0]    CNT_LAST = CW'(N - 1);
    localparam logic [WIDTH-1:0] GRP_MASK = WIDTH'({GW{1'b1}});

    if ((WIDTH % GW) != 0) begin : g_bad_width
        $error("alu181_seq: WIDTH must be a multiple of 4*SPC");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       s_q, s_d;
    logic             m_q, m_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [GW-1:0]    grp_f;
    logic [SPC:0]     grp_c;
    logic [SPC-1:0]   grp_c3;
    logic             grp_cout;
    logic             grp_c_msb;
    logic [31:0]      sh;
    logic [WIDTH-1:0] y_new;

    // Operands shift right after each group, so the slices always read the low GW bits.
    assign grp_c[0] = carry_q;
    for (genvar k = 0; k < SPC; k++) begin : g_slice
        alu181_slice u_slice (
            .s_i    (s_q),
            .m_i    (m_q),
            .cin_i  (grp_c[k]),
            .a_i    (a_q[4*k +: 4]),
            .b_i    (b_q[4*k +: 4]),
            .f_o    (grp_f[4*k +: 4]),
            .cout_o (grp_c[k+1]),
            .c3_o   (grp_c3[k])
        );
    end

    assign grp_cout  = grp_c[SPC];
    assign grp_c_msb = 1'(grp_c3 >> (SPC - 1));
    assign sh        = 32'(cnt_q) * GW;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        m_d     = m_q;
        carry_d = carry_q;
        y_d     = y_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        y_new   = (y_q & ~(GRP_MASK << sh)) | (WIDTH'(grp_f) << sh);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    s_d     = s;
                    m_d     = m;
                    carry_d = cin & ~m;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                y_d     = y_new;
                carry_d = grp_cout;
                a_d     = a_q >> GW;
                b_d     = b_q >> GW;
                if (cnt_q == CNT_LAST) begin
                    cout_d  = grp_cout & ~m_q;
                    ovf_d   = (grp_c_msb ^ grp_cout) & ~m_q;
                    zero_d  = (y_new == '0);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            y_q     <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            m_q     <= m_d;
            carry_q <= carry_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu181_seq.sv
// Directed bench for alu181_seq: 16-bit/SPC=1 and 32-bit/SPC=2 instances.
module tb_alu181_seq;
    import alu181_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, m, cin;
    logic [3:0]  s;
    logic [15:0] a, b, y;
    logic        in_ready, out_valid, cout, zero, ovf;

    logic        w_rst, w_in_valid, w_out_ready, w_m, w_cin;
    logic [3:0]  w_s;
    logic [31:0] w_a, w_b, w_y;
    logic        w_in_ready, w_out_valid, w_cout, w_zero, w_ovf;

    int vectors = 0;
    int errors  = 0;
    int lat;

    alu181_seq #(.WIDTH(16), .SPC(1)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .m(m), .cin(cin), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .cout(cout), .zero(zero), .ovf(ovf)
    );

    alu181_seq #(.WIDTH(32), .SPC(2)) u_dut32 (
        .clk(clk), .rst(w_rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .s(w_s), .m(w_m), .cin(w_cin), .a(w_a), .b(w_b),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .y(w_y), .cout(w_cout), .zero(w_zero), .ovf(w_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one op on the 16-bit unit and wait (bounded) for out_valid; leaves it in DONE.
    task automatic issue16(input logic [15:0] ta, input logic [15:0] tb_v, input logic [3:0] ts,
                           input logic tm, input logic tc, output int tlat);
        @(negedge clk);
        a = ta; b = tb_v; s = ts; m = tm; cin = tc; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        tlat = 0;
        while (!out_valid && tlat < 20) begin
            @(posedge clk);
            tlat++;
            @(negedge clk);
        end
    endtask

    task automatic release16();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic [3:0] ts, input logic tm, input logic tc,
                         input logic [15:0] ey, input logic ec, input logic ez, input logic eo);
        int l;
        issue16(ta, tb_v, ts, tm, tc, l);
        chk({tag, ".lat"}, 32'(l), 32'd4);
        chk({tag, ".y"}, 32'(y), 32'(ey));
        chk({tag, ".cout"}, 32'(cout), 32'(ec));
        chk({tag, ".zero"}, 32'(zero), 32'(ez));
        chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
        release16();
    endtask

    task automatic run32(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [3:0] ts, input logic tm, input logic tc,
                         input logic [31:0] ey, input logic ec, input logic ez, input logic eo);
        int l;
        @(negedge clk);
        w_a = ta; w_b = tb_v; w_s = ts; w_m = tm; w_cin = tc; w_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        w_in_valid = 1'b0;
        l = 0;
        while (!w_out_valid && l < 20) begin
            @(posedge clk);
            l++;
            @(negedge clk);
        end
        chk({tag, ".lat"}, 32'(l), 32'd4);
        chk({tag, ".y"}, w_y, ey);
        chk({tag, ".cout"}, 32'(w_cout), 32'(ec));
        chk({tag, ".zero"}, 32'(w_zero), 32'(ez));
        chk({tag, ".ovf"}, 32'(w_ovf), 32'(eo));
        @(negedge clk);
        w_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        w_out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; m = 1'b0; cin = 1'b0;
        s = 4'h0; a = '0; b = '0;
        w_rst = 1'b1; w_in_valid = 1'b0; w_out_ready = 1'b0; w_m = 1'b0; w_cin = 1'b0;
        w_s = 4'h0; w_a = '0; w_b = '0;
        #12;
        chk("rst.y", 32'(y), 32'h0);
        chk("rst.cout", 32'(cout), 32'h0);
        chk("rst.zero", 32'(zero), 32'h0);
        chk("rst.ovf", 32'(ovf), 32'h0);
        chk("rst.out_valid", 32'(out_valid), 32'h0);
        chk("rst.in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0; w_rst = 1'b0;

        run16("add",     16'h1234, 16'h0FFF, S_ADD,   1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
        chk("add.in_ready_after", 32'(in_ready), 32'h1);
        chk("add.out_valid_after", 32'(out_valid), 32'h0);
        run16("sub",     16'h8000, 16'h0001, S_SUB,   1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1);
        run16("xor",     16'hFF00, 16'h0FF0, S_XOR,   1'b1, 1'b0, 16'hF0F0, 1'b0, 1'b0, 1'b0);
        run16("xor_cin", 16'hFF00, 16'h0FF0, S_XOR,   1'b1, 1'b1, 16'hF0F0, 1'b0, 1'b0, 1'b0);
        run16("xor_eq",  16'hABCD, 16'hABCD, S_XOR,   1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        run16("and",     16'hF0F0, 16'hFF00, S_AND,   1'b1, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b0);
        run16("or",      16'hF0F0, 16'hFF00, S_OR,    1'b1, 1'b1, 16'hFFF0, 1'b0, 1'b0, 1'b0);
        run16("nota",    16'h1234, 16'h5555, S_NOTA,  1'b1, 1'b0, 16'hEDCB, 1'b0, 1'b0, 1'b0);
        run16("zero",    16'h1234, 16'h5555, S_ZERO,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        run16("ones",    16'h1234, 16'h5555, S_ONES,  1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run16("passa",   16'h5A5A, 16'h1111, S_PASSA, 1'b1, 1'b0, 16'h5A5A, 1'b0, 1'b0, 1'b0);
        run16("dec5",    16'h0005, 16'h0000, S_PASSA, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0);
        run16("dec0",    16'h0000, 16'h0000, S_PASSA, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run16("inc_wrap",16'hFFFF, 16'h0000, S_NOTA,  1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        run16("add_ovf", 16'h7FFF, 16'h0001, S_ADD,   1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);

        // Backpressure: hold DONE while junk requests are presented.
        issue16(16'h0101, 16'h0202, S_ADD, 1'b0, 1'b0, lat);
        chk("bp.lat", 32'(lat), 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); s = S_ONES; m = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("bp.in_ready", 32'(in_ready), 32'h0);
            chk("bp.out_valid", 32'(out_valid), 32'h1);
            chk("bp.y", 32'(y), 32'h0303);
            chk("bp.zero", 32'(zero), 32'h0);
        end
        in_valid = 1'b0;
        release16();
        chk("bp.in_ready_idle", 32'(in_ready), 32'h1);
        chk("bp.out_valid_idle", 32'(out_valid), 32'h0);
        chk("bp.y_hold_idle", 32'(y), 32'h0303);
        run16("bp.next", 16'h00FF, 16'h0001, S_ADD, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

        // Reset after two slice edges of an in-flight op.
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; s = S_ADD; m = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_run.out_valid", 32'(out_valid), 32'h0);
        chk("rst_run.y", 32'(y), 32'h0);
        chk("rst_run.in_ready", 32'(in_ready), 32'h1);
        chk("rst_run.cout", 32'(cout), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_run.no_pulse", 32'(out_valid), 32'h0);
        run16("rst_run.add", 16'h0001, 16'h0001, S_ADD, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

        chk("w.in_ready", 32'(w_in_ready), 32'h1);
        run32("w.add_wrap", 32'hFFFFFFFF, 32'h00000001, S_ADD, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0);
        run32("w.add_ovf",  32'h7FFFFFFF, 32'h00000001, S_ADD, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1);
        run32("w.sub",      32'h12345678, 32'h00000678, S_SUB, 1'b0, 1'b1, 32'h12345000, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
